fifo_stim_gen: RTL and testbench
================================

Name: fifo_stim_gen

Overview:
- Synthesizable stimulus source for the synchronous FIFO: the driving end of the FIFO interface that the monitor observes.
- Produces wr_en/rd_en/data_in/rst_n vectors from a seeded LFSR under programmable probabilities.
- Pulses a strobe per applied vector (the monitor's sampling trigger) and flags completion after a fixed transaction count plus a drain phase.
- Used for on-chip and emulation self-test; sits directly on the FIFO write/read ports, alongside the monitor.

Parameters:
- FIFO_WIDTH, 16, data_in width; legal range 1..32.
- FIFO_DEPTH, 8, number of drain cycles issued after the run phase.
- NUM_TXN, 1000, stimulus vectors applied in RUN; must be >= 1.
- SEED, 32'hACE1ACE1, LFSR load value on reset and on start; must be non-zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence; sampled only in IDLE and DONE.
- wr_thresh  in  8  write probability; wr_en=1 when lfsr[7:0] < wr_thresh, or when wr_thresh==8'hFF.
- rd_thresh  in  8  read probability; same rule applied to lfsr[15:8].
- rst_thresh  in  8  DUT reset probability; fifo_rst_n=0 when lfsr[23:16] < rst_thresh (8'hFF means always).
- fifo_rst_n  out  1  active-low reset to the FIFO.
- wr_en  out  1  FIFO write enable.
- rd_en  out  1  FIFO read enable.
- data_in  out  FIFO_WIDTH  FIFO write data, equal to lfsr[31 -: FIFO_WIDTH].
- txn_strobe  out  1  high for exactly the cycles in which a RUN vector is applied.
- busy  out  1  high in RESET_DUT, RUN and DRAIN.
- done  out  1  sticky; set on entering DONE, cleared by start or rst.

Behaviour:
- All outputs are registered, so the FIFO sees stable values at its next rising edge and the monitor samples them at the negedge.
- Reset (async, while rst=1):
  - state=IDLE, lfsr=SEED, counters=0.
  - fifo_rst_n=0, wr_en=0, rd_en=0, data_in=0, txn_strobe=0, busy=0, done=0.
- IDLE: holds fifo_rst_n=0 and all enables at 0. On start=1: reload lfsr=SEED, clear txn_cnt and drain_cnt, go to RESET_DUT.
- RESET_DUT: exactly 2 cycles with fifo_rst_n=0, enables at 0 and busy=1; then go to RUN.
- RUN: each cycle applies one vector derived from the current lfsr value, then advances the lfsr once.
  - The first RUN vector uses SEED itself.
  - Outputs: txn_strobe=1; wr_en, rd_en and fifo_rst_n per the threshold rules; data_in from lfsr.
  - txn_cnt increments per vector. After vector NUM_TXN has been applied, go to DRAIN.
- LFSR: 32-bit Galois, shift right. If lfsr[0]=1, next=(lfsr>>1)^32'h80200003; otherwise next=lfsr>>1. The LFSR never reaches 0 from a non-zero seed.
- DRAIN: exactly FIFO_DEPTH cycles with rd_en=1, wr_en=0, fifo_rst_n=1, txn_strobe=0 and data_in held; then go to DONE.
- DONE: done=1, busy=0, all enables 0, fifo_rst_n=1 (FIFO contents remain observable). start=1 behaves as in IDLE.
- start during RESET_DUT, RUN or DRAIN is ignored.
- rst asserted mid-sequence returns the block to IDLE immediately with reset values; the partial sequence is discarded.
- Threshold inputs are sampled every RUN cycle and may change on the fly.
- Counters are sized to $clog2(NUM_TXN+1) and $clog2(FIFO_DEPTH+1); they never wrap.

Test Plan:
1. Reset: assert rst with start=1 -> fifo_rst_n=0, wr_en=rd_en=0, data_in=0, txn_strobe=busy=done=0; state stays IDLE after release until the next start.
2. Sequence timing: NUM_TXN=4, wr_thresh=FF, rd_thresh=00, rst_thresh=00, pulse start -> 2 cycles fifo_rst_n=0, then 4 cycles wr_en=1/txn_strobe=1, then 8 cycles rd_en=1, then done=1 and busy=0.
3. LFSR values: default SEED, FIFO_WIDTH=16 -> first RUN data_in=16'hACE1 and second data_in=16'hD650. With wr_thresh=8'hE2 the first wr_en=1; with 8'hE1 it is 0.
4. Zero probabilities: all thresholds 00, NUM_TXN=10 -> exactly 10 txn_strobe pulses; wr_en=rd_en=0 and fifo_rst_n=1 throughout RUN.
5. Interruptions: pulse start during RUN -> ignored and txn_cnt unaffected. Assert rst in RUN vector 3 -> outputs go to reset values in the same cycle; a following start reproduces the identical vector sequence.
6. Restart from DONE: pulse start in DONE -> done clears the next cycle; the sequence repeats bit-exactly, including data_in values.

Source files
------------

// File: rtl/fifo_stim_gen.sv
// rtl/fifo_stim_gen.sv - LFSR-driven stimulus source for the synchronous FIFO write/read ports
module fifo_stim_gen #(
  parameter int          FIFO_WIDTH = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter int          NUM_TXN    = 1000,
  parameter logic [31:0] SEED       = 32'hACE1ACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            wr_thresh,
  input  logic [7:0]            rd_thresh,
  input  logic [7:0]            rst_thresh,
  output logic                  fifo_rst_n,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  txn_strobe,
  output logic                  busy,
  output logic                  done
);

  localparam int TW = $clog2(NUM_TXN + 1);
  localparam int DW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_DUT,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [31:0]     lfsr, lfsr_n;
  logic [TW-1:0]   txn_cnt, txn_cnt_n;
  logic [DW-1:0]   drain_cnt, drain_cnt_n;
  logic            rdut_cnt, rdut_cnt_n;
  logic            apply_vec;

  logic                  fifo_rst_n_n, wr_en_n, rd_en_n, txn_strobe_n, busy_n, done_n;
  logic [FIFO_WIDTH-1:0] data_in_n;

  logic wr_hit, rd_hit, rst_hit;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  assign wr_hit  = (lfsr[7:0]   < wr_thresh)  || (wr_thresh  == 8'hFF);
  assign rd_hit  = (lfsr[15:8]  < rd_thresh)  || (rd_thresh  == 8'hFF);
  assign rst_hit = (lfsr[23:16] < rst_thresh) || (rst_thresh == 8'hFF);

  // Outputs are computed alongside the next state and registered, so the
  // visible outputs always describe the state currently held.
  always_comb begin
    state_n      = state;
    lfsr_n       = lfsr;
    txn_cnt_n    = txn_cnt;
    drain_cnt_n  = drain_cnt;
    rdut_cnt_n   = rdut_cnt;
    apply_vec    = 1'b0;
    fifo_rst_n_n = fifo_rst_n;
    wr_en_n      = 1'b0;
    rd_en_n      = 1'b0;
    data_in_n    = data_in;
    txn_strobe_n = 1'b0;
    busy_n       = busy;
    done_n       = done;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n      = S_RESET_DUT;
          lfsr_n       = SEED;
          txn_cnt_n    = '0;
          drain_cnt_n  = '0;
          rdut_cnt_n   = 1'b0;
          fifo_rst_n_n = 1'b0;
          busy_n       = 1'b1;
          done_n       = 1'b0;
        end
      end
      S_RESET_DUT: begin
        if (!rdut_cnt) begin
          rdut_cnt_n = 1'b1;
        end else begin
          state_n   = S_RUN;
          apply_vec = 1'b1;
        end
      end
      S_RUN: begin
        if (txn_cnt == TW'(NUM_TXN)) begin
          state_n      = S_DRAIN;
          rd_en_n      = 1'b1;
          fifo_rst_n_n = 1'b1;
          drain_cnt_n  = DW'(1);
        end else begin
          apply_vec = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DW'(FIFO_DEPTH)) begin
          state_n      = S_DONE;
          fifo_rst_n_n = 1'b1;
          busy_n       = 1'b0;
          done_n       = 1'b1;
        end else begin
          rd_en_n     = 1'b1;
          drain_cnt_n = drain_cnt + DW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (apply_vec) begin
      txn_strobe_n = 1'b1;
      wr_en_n      = wr_hit;
      rd_en_n      = rd_hit;
      fifo_rst_n_n = !rst_hit;
      data_in_n    = lfsr[31 -: FIFO_WIDTH];
      lfsr_n       = lfsr_step(lfsr);
      txn_cnt_n    = txn_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lfsr       <= SEED;
      txn_cnt    <= '0;
      drain_cnt  <= '0;
      rdut_cnt   <= 1'b0;
      fifo_rst_n <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      data_in    <= '0;
      txn_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      lfsr       <= lfsr_n;
      txn_cnt    <= txn_cnt_n;
      drain_cnt  <= drain_cnt_n;
      rdut_cnt   <= rdut_cnt_n;
      fifo_rst_n <= fifo_rst_n_n;
      wr_en      <= wr_en_n;
      rd_en      <= rd_en_n;
      data_in    <= data_in_n;
      txn_strobe <= txn_strobe_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_fifo_stim_gen.sv
// tb/tb_fifo_stim_gen.sv - randomized self-checking bench for fifo_stim_gen
module tb_fifo_stim_gen;

  localparam int          FW = 16;
  localparam int          FD = 8;
  localparam int          NT = 10;
  localparam logic [31:0] SD = 32'hACE1ACE1;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [7:0]    wt, rt, xt;
  logic          fifo_rst_n, wr_en, rd_en, txn_strobe, busy, done;
  logic [FW-1:0] data_in;

  always #5 clk = ~clk;

  fifo_stim_gen #(.FIFO_WIDTH(FW), .FIFO_DEPTH(FD), .NUM_TXN(NT), .SEED(SD)) dut (
    .clk(clk), .rst(rst), .start(start),
    .wr_thresh(wt), .rd_thresh(rt), .rst_thresh(xt),
    .fifo_rst_n(fifo_rst_n), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .txn_strobe(txn_strobe), .busy(busy), .done(done)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: position within a sequence is a plain cycle index since start.
  bit            m_active, m_done;
  int            m_i;
  logic [31:0]   m_lfsr;
  logic          e_rstn, e_wr, e_rd, e_stb, e_busy, e_done;
  logic [FW-1:0] e_data;
  logic [FW-1:0] q_ref[$];
  bit            rec;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_i = 0;
    e_rstn = 0; e_wr = 0; e_rd = 0; e_stb = 0; e_busy = 0; e_done = 0; e_data = '0;
  endtask

  task automatic model_edge();
    e_wr = 0; e_rd = 0; e_stb = 0;
    if (m_active) m_i++;
    else if (start) begin
      m_active = 1; m_i = 0; m_done = 0; m_lfsr = SD;
    end
    if (m_active && m_i >= 2 + NT + FD) begin
      m_active = 0; m_done = 1;
    end
    if (m_active) begin
      e_busy = 1; e_done = 0;
      if (m_i < 2) e_rstn = 0;
      else if (m_i < 2 + NT) begin
        e_stb  = 1;
        e_wr   = (m_lfsr[7:0] < wt) || (wt == 8'hFF);
        e_rd   = (m_lfsr[15:8] < rt) || (rt == 8'hFF);
        e_rstn = !((m_lfsr[23:16] < xt) || (xt == 8'hFF));
        e_data = m_lfsr[31 -: FW];
        if (rec) q_ref.push_back(e_data);
        m_lfsr = lfsr_next(m_lfsr);
      end else begin
        e_rd = 1; e_rstn = 1;
      end
    end else begin
      e_busy = 0; e_done = m_done; e_rstn = m_done;
    end
  endtask

  task automatic compare_all();
    check("fifo_rst_n", fifo_rst_n, e_rstn);
    check("wr_en", wr_en, e_wr);
    check("rd_en", rd_en, e_rd);
    check("data_in", data_in, e_data);
    check("txn_strobe", txn_strobe, e_stb);
    check("busy", busy, e_busy);
    check("done", done, e_done);
  endtask

  task automatic tick(input logic s);
    start = s;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    start = 1'b0;
  endtask

  // Called just after a negedge; reset must act without waiting for a clock.
  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  int stb_cnt;
  int k;

  initial begin
    rst = 1'b1; start = 1'b1; wt = 8'h00; rt = 8'h00; xt = 8'h00; rec = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    compare_all();
    rst = 1'b0; start = 1'b0;
    repeat (3) tick(1'b0);
    check("idle_busy", busy, 1'b0);

    // Directed run: first-vector data and threshold boundary
    wt = 8'hE2;
    tick(1'b1); tick(1'b0); tick(1'b0);
    check("first_data", data_in, 16'hACE1);
    check("first_wr_e2", wr_en, 1'b1);
    wt = 8'hFF;
    tick(1'b0);
    check("second_data", data_in, 16'hD650);
    repeat (25) tick(1'b0);
    check("done_set", done, 1'b1);

    wt = 8'hE1;
    tick(1'b1);
    check("done_clear", done, 1'b0);
    tick(1'b0); tick(1'b0);
    check("first_wr_e1", wr_en, 1'b0);
    check("restart_data", data_in, 16'hACE1);
    repeat (25) tick(1'b0);

    // Zero probabilities, also recording the reference data sequence
    wt = 8'h00; rt = 8'h00; xt = 8'h00; stb_cnt = 0; rec = 1;
    tick(1'b1);
    for (int i = 0; i < 24; i++) begin
      tick(1'b0);
      if (txn_strobe) stb_cnt++;
    end
    rec = 0;
    check("zero_strobes", stb_cnt, NT);
    check("ref_len", q_ref.size(), NT);

    // Start mid-RUN ignored, then rst during vector 3
    wt = 8'h80; rt = 8'h40; xt = 8'h10;
    tick(1'b1); tick(1'b0); tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    check("vec3_strobe", txn_strobe, 1'b1);
    pulse_rst();
    k = 0;
    tick(1'b1);
    for (int i = 0; i < 24; i++) begin
      tick(1'b0);
      if (txn_strobe) begin
        if (k < q_ref.size()) check("replay_data", data_in, q_ref[k]);
        k++;
      end
    end
    check("replay_len", k, NT);

    // Randomized traffic with on-the-fly thresholds, starts and resets
    for (int i = 0; i < 300; i++) begin
      wt = 8'($urandom); rt = 8'($urandom); xt = 8'($urandom);
      if ($urandom_range(0, 3) == 0) wt = 8'hFF;
      if ($urandom_range(0, 59) == 0) pulse_rst();
      else tick($urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
